// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path: command codes, scheduler
// state encoding and the settle-counter width.
package alu_ctrl_pkg;

   localparam logic [2:0] CMD_ADD  = 3'd0;
   localparam logic [2:0] CMD_SUB  = 3'd1;
   localparam logic [2:0] CMD_XOR  = 3'd2;
   localparam logic [2:0] CMD_SLT  = 3'd3;
   localparam logic [2:0] CMD_AND  = 3'd4;
   localparam logic [2:0] CMD_NAND = 3'd5;
   localparam logic [2:0] CMD_NOR  = 3'd6;
   localparam logic [2:0] CMD_OR   = 3'd7;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// priority pointer (0 = requester 0 preferred on a tie).
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_request_scheduler.sv
// Arbitrates two requesters onto the shared structural ALU, holds its
// operands for a settle window, then returns the captured result and flags.
module alu_request_scheduler
   import alu_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4   // 1..15, must cover the ALU's worst-case delay
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_cmd,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_cmd,

   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_cmd,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout,
   input  logic        alu_zero,
   input  logic        alu_overflow,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_carryout,
   output logic        rsp_zero,
   output logic        rsp_overflow,

   output logic        busy,
   output logic [1:0]  fsm_state
);

   localparam cnt_t CNT_LOAD = cnt_t'(SETTLE_CYCLES - 1);

   logic [1:0] state;
   logic       ptr;
   cnt_t       cnt;
   logic [1:0] grant;

   rr_arbiter2 u_arb (
      .valid (({req1_valid, req0_valid})),
      .ptr   (ptr),
      .grant (grant)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high. req*_ready is combinational on req*_valid, so requesters
   // must never wait for ready before raising valid. rsp_valid stays high,
   // with rsp_* frozen, until an edge sees rsp_ready high.
   assign req0_ready = !reset && (state == ST_IDLE) && grant[0];
   assign req1_ready = !reset && (state == ST_IDLE) && grant[1];
   assign busy       = (state != ST_IDLE);
   assign fsm_state  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         ptr          <= 1'b0;
         cnt          <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_cmd      <= CMD_ADD;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  alu_a   <= grant[1] ? req1_a   : req0_a;
                  alu_b   <= grant[1] ? req1_b   : req0_b;
                  alu_cmd <= grant[1] ? req1_cmd : req0_cmd;
                  rsp_id  <= grant[1];
                  cnt     <= CNT_LOAD;
                  // Next tie goes to whoever lost this one.
                  ptr     <= grant[0];
                  state   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) begin
                  rsp_result   <= alu_result;
                  rsp_carryout <= alu_carryout;
                  rsp_zero     <= alu_zero;
                  rsp_overflow <= alu_overflow;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  cnt <= cnt - cnt_t'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Bench for alu_request_scheduler: behavioural ALU, two requester drivers,
// a response-side scoreboard with a grant/latency model, directed and random phases.
module tb_alu_request_scheduler;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]  req0_cmd = '0, req1_cmd = '0;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_cmd;
   logic        alu_carryout, alu_zero, alu_overflow;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_carryout, rsp_zero, rsp_overflow;
   logic        busy;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bp_mode = 1;   // 0 random rsp_ready, 1 always high, 2 held low

   // Scoreboard entries: {id, result, carryout, zero, overflow}
   logic [35:0] exp_q[$];
   bit          m_idle = 1'b1;
   bit          m_ptr = 1'b0;
   int          m_due = 0;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_cmd;

   alu_request_scheduler #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
      .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .busy(busy), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural ALU ----------------
   function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, o;
      c = 1'b0; o = 1'b0; r = '0;
      case (cmd)
         3'd0: begin s = {1'b0, a} + {1'b0, b};  r = s[31:0]; c = s[32]; o = (a[31] == b[31]) && (r[31] != a[31]); end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; o = (a[31] != b[31]) && (r[31] != a[31]); end
         3'd2: r = a ^ b;
         3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {r, c, (r == 32'd0), o};
   endfunction

   always_comb begin
      {alu_result, alu_carryout, alu_zero, alu_overflow} = alu_ref(alu_a, alu_b, alu_cmd);
   end

   function automatic logic [35:0] exp_rsp(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
      return {id, alu_ref(a, b, cmd)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   always @(posedge clk) begin
      #1;
      if (bp_mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = (bp_mode == 1);
   end

   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd, input int gap);
      bit done = 1'b0;
      if (id == 0) begin req0_a = a; req0_b = b; req0_cmd = cmd; req0_valid = 1'b1; end
      else         begin req1_a = a; req1_b = b; req1_cmd = cmd; req1_valid = 1'b1; end
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if ((id == 0) ? req0_ready : req1_ready) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: requester %0d never accepted", id);
      end
      @(posedge clk); #1;
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
   endtask

   task automatic wait_rsp();
      bit seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
      end
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [1:0] vld, g;
      chk("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (reset) begin
         exp_q.delete();
         m_idle = 1'b1;
         m_ptr  = 1'b0;
         chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
         chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
         chk("rst_busy", {63'd0, busy}, 64'd0);
         chk("rst_alu", {alu_a, alu_b[28:0], alu_cmd}, 64'd0);
         chk("rst_rsp", {rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, 64'd0);
      end else if (!m_idle) begin
         chk("busy_active", {63'd0, busy}, 64'd1);
         chk("ready_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
         chk("alu_frozen", {29'd0, alu_cmd, alu_a}, {29'd0, m_cmd, m_a});
         chk("alu_b_frozen", {32'd0, alu_b}, {32'd0, m_b});
         if (cyc < m_due) begin
            chk("rsp_valid_early", {63'd0, rsp_valid}, 64'd0);
         end else begin
            chk("rsp_valid_due", {63'd0, rsp_valid}, 64'd1);
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
               m_idle = 1'b1;
            end else begin
               chk("rsp_fields", {28'd0, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, {28'd0, exp_q[0]});
               if (rsp_valid && rsp_ready) begin
                  void'(exp_q.pop_front());
                  m_idle = 1'b1;
               end
            end
         end
      end else begin
         chk("idle_busy", {63'd0, busy}, 64'd0);
         chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
         vld = {req1_valid, req0_valid};
         if (vld == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
         else g = vld;
         chk("grant", {62'd0, req1_ready, req0_ready}, {62'd0, g});
         if (g != 2'b00) begin
            m_a   = g[1] ? req1_a : req0_a;
            m_b   = g[1] ? req1_b : req0_b;
            m_cmd = g[1] ? req1_cmd : req0_cmd;
            exp_q.push_back(exp_rsp(g[1], m_a, m_b, m_cmd));
            m_ptr  = ~g[1];
            m_due  = cyc + 1 + S;
            m_idle = 1'b0;
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [35:0] snap;
      bit drained;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Directed single operations
      issue(0, 32'd5, 32'd7, 3'd0, 0);
      wait_rsp();
      chk("add_result", {32'd0, rsp_result}, 64'd12);
      chk("add_flags", {61'd0, rsp_carryout, rsp_zero, rsp_overflow}, 64'd0);
      chk("add_id", {63'd0, rsp_id}, 64'd0);

      issue(1, 32'd5, 32'd5, 3'd1, 0);
      wait_rsp();
      chk("sub_result", {32'd0, rsp_result}, 64'd0);
      chk("sub_flags", {61'd0, rsp_carryout, rsp_zero, rsp_overflow}, {61'd0, 3'b110});
      chk("sub_id", {63'd0, rsp_id}, 64'd1);

      issue(0, 32'hFFFF_FFFF, 32'd1, 3'd3, 0);
      wait_rsp();
      chk("slt_result", {32'd0, rsp_result}, 64'd1);

      issue(1, 32'h7FFF_FFFF, 32'd1, 3'd0, 0);
      wait_rsp();
      chk("ovf_result", {32'd0, rsp_result}, 64'h8000_0000);
      chk("ovf_flags", {61'd0, rsp_carryout, rsp_zero, rsp_overflow}, {61'd0, 3'b001});
      repeat (2) @(posedge clk); #1;

      // Both requesters valid across reset release; order must be 0,1,0,1
      reset = 1'b1;
      fork
         begin issue(0, 32'd10, 32'd3, 3'd1, 0); issue(0, 32'hF0F0, 32'h0FF0, 3'd2, 0); end
         begin issue(1, 32'd100, 32'd200, 3'd0, 0); issue(1, 32'hAAAA, 32'h5555, 3'd7, 0); end
         begin repeat (2) @(posedge clk); #1 reset = 1'b0; end
      join
      repeat (3 * (S + 2)) @(posedge clk); #1;

      // Response backpressure: stalled in RESP, requester 1 waiting
      bp_mode = 2;
      fork
         issue(0, 32'h1234_5678, 32'h1111_1111, 3'd1, 0);
         begin
            @(posedge clk); #1;
            issue(1, 32'd9, 32'd9, 3'd4, 0);
         end
         begin
            wait_rsp();
            snap = {rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow};
            repeat (5) begin
               @(negedge clk);
               chk("bp_hold", {28'd0, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, {28'd0, snap});
               chk("bp_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
               chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            end
            bp_mode = 1;
            @(negedge clk);
            chk("bp_still_resp", {63'd0, busy}, 64'd1);
            @(negedge clk);
            chk("bp_released", {62'd0, busy, rsp_valid}, 64'd0);
         end
      join
      repeat (S + 4) @(posedge clk); #1;

      // Reset one cycle after accept drops the operation
      issue(0, 32'hDEAD_0000, 32'h0000_BEEF, 3'd7, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_alu", {alu_a, alu_b[28:0], alu_cmd}, 64'd0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      repeat (2 * S + 4) @(posedge clk); #1;

      // Randomized traffic from both requesters with random response backpressure
      bp_mode = 0;
      fork
         for (int i = 0; i < 40; i++)
            issue(0, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
         for (int j = 0; j < 40; j++)
            issue(1, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      join
      bp_mode = 1;
      drained = 1'b0;
      for (int k = 0; k < 200 && !drained; k++) begin
         @(negedge clk);
         if (m_idle && exp_q.size() == 0) drained = 1'b1;
      end
      chk("drained", {63'd0, drained}, 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_request_scheduler.md
# alu_request_scheduler

Sequencer and two-port arbiter for the shared 32-bit structural ALU (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR).

- Accepts operations from two requesters over valid/ready handshakes and grants them round-robin.
- Holds the ALU inputs stable for a programmable settle window, covering the ripple-carry and 32-input NOR gate delays.
- Captures result and flags, then returns them with the requester ID over a valid/ready response channel.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: clock edges the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  request accepted this edge when valid is also high
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_cmd / req1_cmd  in  3  ALU command, 0..7 = ADD, SUB, XOR, SLT, AND, NAND, NOR, OR
- alu_a, alu_b  out  32  to ALU operandA/operandB
- alu_cmd  out  3  to ALU command
- alu_result  in  32  from ALU
- alu_carryout, alu_zero, alu_overflow  in  1  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  0 = requester 0, 1 = requester 1
- rsp_result  out  32  captured result
- rsp_carryout, rsp_zero, rsp_overflow  out  1  captured flags
- busy  out  1  state is not IDLE

## Operation
States: IDLE, SETTLE, RESP.

IDLE:
- Arbiter asserts ready to exactly one requester, the granted one, and only when it is valid.
- Grant rule: if both requesters are valid, grant the requester indicated by the priority pointer; if only one is valid, grant it.
- On an accept edge:
  - Register a, b and cmd of the granted requester into alu_a/alu_b/alu_cmd.
  - Record rsp_id.
  - Load cnt = SETTLE_CYCLES-1 and go to SETTLE.
  - Set the pointer to the non-granted requester.

SETTLE:
- alu_a/alu_b/alu_cmd are frozen.
- At each edge, if cnt==0: capture alu_result and the three flags into rsp_* registers, set rsp_valid, and go to RESP. Otherwise decrement cnt.

RESP:
- rsp_* and alu_* are held stable while rsp_valid is high and rsp_ready is low.
- Edge with rsp_ready high: clear rsp_valid and go to IDLE.

General rules:
- Both ready outputs are 0 in SETTLE and RESP; no request is accepted outside IDLE.
- req*_ready may depend combinationally on req*_valid. The requester must not make valid depend on ready.
- The block does not interpret commands. Flags pass through from the ALU unmodified, including overflow gating, which the ALU itself performs.

Reset values (asserted asynchronously, any state):
- state = IDLE, pointer = requester 0, cnt = 0.
- alu_a = alu_b = 0, alu_cmd = 0 (ADD).
- rsp_valid = 0, rsp_id = 0, rsp_result = 0, all rsp flags = 0, busy = 0.
- Both ready outputs are 0 while reset is high.
- A reset during SETTLE or RESP drops the in-flight operation with no response.

## Timing
- Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge.
- Minimum issue period with rsp_ready tied high: SETTLE_CYCLES+2 edges (accept, SETTLE_CYCLES settle edges, response handshake edge, then IDLE).
- SETTLE_CYCLES × clock period must exceed the worst-case ALU delay. At the model's gate delays this is about 1.3 µs for a 32-bit SUB.
- Simultaneous valid on both requesters at reset exit: req0 is granted first and req1 on the next IDLE.
- A requester held valid continuously alternates with the other one; neither is starved.
- Response backpressure stalls the block indefinitely in RESP; requests wait.

## Structure
- Shared package alu_ctrl_pkg holds:
  - 3-bit command constants ADD=0 … OR=7, shared with the ALU control lookup.
  - State encoding IDLE/SETTLE/RESP.
  - Counter width of 4 bits.
- Sub-module rr_arbiter2: combinational two-way round-robin grant from valid bits and the pointer. The pointer register lives in the parent.
- The ALU is instantiated outside this block; this block only drives and samples its ports.

## Test plan
- ADD: req0 a=5, b=7, cmd=0 → rsp_valid exactly SETTLE_CYCLES edges after accept; rsp_result=12, zero=0, overflow=0, rsp_id=0.
- SUB: req1 a=5, b=5, cmd=1 → result=0, zero=1, carryout=1, rsp_id=1. SLT: a=0xFFFFFFFF, b=1, cmd=3 → result=1.
- Overflow: a=0x7FFFFFFF, b=1, ADD → result=0x80000000, overflow=1, carryout=0.
- Arbitration: both valid at reset release with distinct ops → responses in order id 0, 1, 0, 1 while both stay valid; ready never high for both requesters in the same cycle.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_* stable, both ready outputs 0, no accept; rsp_ready high → IDLE next edge.
- Reset mid-SETTLE: assert reset 1 cycle after accept → immediately rsp_valid=0, busy=0, alu_* = 0; no response is ever produced for the dropped op.
